imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
Shares the single-port synchronous instruction RAM between the IF-stage fetch path and a load/store (LSU/loader) requester. Decides per-cycle ownership and drives the RAM port. Routes the 1-cycle-latency read data back to the owner that issued the request. Raises a fetch stall toward the pipeline controller whenever fetch loses arbitration, and bounds LSU starvation of fetch.

Parameters:
MAX_LSU_RUN, 4, consecutive contended LSU grants allowed before fetch is forced one slot (1..15)
ADDR_W, 32, RAM byte-address width

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-high reset
fetch_enable_i  in  1  IF requests a fetch this cycle
fetch_addr_i  in  ADDR_W  fetch address
fetch_rdata_o  out  32  instruction data to IF/ID register
fetch_stall_o  out  1  fetch not granted this cycle (to pipeline ctrl)
lsu_req_i  in  1  LSU access request
lsu_we_i  in  1  1 = write
lsu_be_i  in  4  byte enables
lsu_addr_i  in  ADDR_W  LSU address
lsu_wdata_i  in  32  write data
lsu_gnt_o  out  1  LSU request accepted this cycle
lsu_rvalid_o  out  1  LSU read data valid
lsu_rdata_o  out  32  LSU read data
ram_en_o  out  1  RAM access enable
ram_we_o  out  1  RAM write enable
ram_be_o  out  4  RAM byte enables
ram_addr_o  out  ADDR_W  RAM address
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data, valid 1 cycle after a read access

Behaviour:
- Grant is combinational, same cycle. Only one of fetch_gnt/lsu_gnt is high per cycle.
- Only one requester active: that requester is granted.
- Both requesting: LSU is granted unless run_cnt == MAX_LSU_RUN, in which case fetch is granted.
- run_cnt: +1 on each LSU grant while fetch_enable_i is high, saturating at MAX_LSU_RUN. Cleared to 0 on any fetch grant or any cycle with fetch_enable_i low.
- RAM port muxed combinationally from the winner. ram_en_o = fetch_gnt | lsu_gnt. ram_we_o = lsu_gnt & lsu_we_i.
  - Fetch grants drive be = 4'hF, we = 0, wdata = 0.
  - With no grant, all RAM outputs are 0.
- fetch_stall_o = fetch_enable_i & ~fetch_gnt.
- lsu_gnt_o = lsu_gnt. The LSU must hold its request stable until granted.
- Response FSM (resp_q), states:
  - IDLE: next state FETCH_RSP on fetch grant; LSU_RSP on LSU read grant; IDLE otherwise (LSU writes included).
  - FETCH_RSP / LSU_RSP: same next-state rule, evaluated every cycle. Back-to-back grants chain without bubbles.
- lsu_rvalid_o = (resp_q == LSU_RSP). lsu_rdata_o = ram_rdata_i when valid, else 0.
- fetch_rdata_o:
  - resp_q == FETCH_RSP: ram_rdata_i, also captured into hold_q.
  - Otherwise: hold_q. The instruction stays stable while IF is stalled.
- Reset values:
  - resp_q = IDLE, run_cnt = 0, hold_q = 32'h0000_0013 (NOP).
  - Hence fetch_rdata_o = 32'h0000_0013, lsu_rvalid_o = 0, lsu_rdata_o = 0.
- Reset mid-operation: any outstanding response is discarded and no rvalid is produced after reset.
- Combinational outputs (grants, stall, RAM port) follow the inputs, subject to the reset state of run_cnt.

Optional Feature:
IMEM_ARB_PERF_EN:
- Defined: adds output perf_conflict_cnt_o [31:0], a wrapping counter incremented every cycle both fetch_enable_i and lsu_req_i are high. Reset to 0.
- Undefined: the port and counter do not exist. Arbitration behaviour is identical in both cases.

Decomposition:
- Package imem_arb_pkg holds:
  - enum resp_sel_e {IDLE, FETCH_RSP, LSU_RSP}
  - constant NOP_INSTR = 32'h0000_0013
  - constant BE_FULL = 4'hF
- One natural sub-module, imem_arb_fair_cnt: the saturating run counter, emitting force_fetch = (run_cnt == MAX_LSU_RUN).

Test Plan:
- Reset, then fetch_enable_i=1, fetch_addr_i=0x100 with RAM word 0x00500093 → ram_en_o=1, ram_addr_o=0x100, fetch_stall_o=0; next cycle fetch_rdata_o=0x00500093.
- LSU read 0x200 (RAM 0xDEADBEEF) with no fetch → lsu_gnt_o=1 same cycle; next cycle lsu_rvalid_o=1, lsu_rdata_o=0xDEADBEEF; fetch_rdata_o holds previous value.
- Fetch and LSU both requesting continuously, MAX_LSU_RUN=4 → grant pattern LLLLF repeating; fetch_stall_o high on the L cycles; fetch_rdata_o stable across the stall.
- LSU write 0x300, data 0x12345678, be=4'b0011 → ram_we_o=1, ram_be_o=4'b0011; no lsu_rvalid_o; a later read of 0x300 returns the updated low half.
- Assert rst_i the cycle after an LSU read grant → lsu_rvalid_o stays 0; fetch_rdata_o=0x00000013; run_cnt=0.
- With IMEM_ARB_PERF_EN, 7 contended cycles → perf_conflict_cnt_o=7; without the macro, the build has no such port.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-RAM arbiter.
package imem_arb_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = 4;
    localparam int unsigned RUN_CNT_W = 4;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [BE_W-1:0]   BE_FULL   = 4'hF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_RSP = 2'd1,
        LSU_RSP   = 2'd2
    } resp_sel_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch/LSU/RAM signal bundle of the instruction-RAM arbiter.
// master = requesters and RAM side, slave = the arbiter.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
) ();
    import imem_arb_pkg::*;

    logic                fetch_enable_i;
    logic [ADDR_W-1:0]   fetch_addr_i;
    logic [DATA_W-1:0]   fetch_rdata_o;
    logic                fetch_stall_o;

    logic                lsu_req_i;
    logic                lsu_we_i;
    logic [BE_W-1:0]     lsu_be_i;
    logic [ADDR_W-1:0]   lsu_addr_i;
    logic [DATA_W-1:0]   lsu_wdata_i;
    logic                lsu_gnt_o;
    logic                lsu_rvalid_o;
    logic [DATA_W-1:0]   lsu_rdata_o;

    logic                ram_en_o;
    logic                ram_we_o;
    logic [BE_W-1:0]     ram_be_o;
    logic [ADDR_W-1:0]   ram_addr_o;
    logic [DATA_W-1:0]   ram_wdata_o;
    logic [DATA_W-1:0]   ram_rdata_i;

    modport master (
        output fetch_enable_i, fetch_addr_i,
        input  fetch_rdata_o, fetch_stall_o,
        output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        input  ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );

    modport slave (
        input  fetch_enable_i, fetch_addr_i,
        output fetch_rdata_o, fetch_stall_o,
        input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        output ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

endinterface

// File: rtl/imem_arb_fair_cnt.sv
// Counts consecutive LSU wins over a waiting fetch; force_fetch hands the
// next contended slot to fetch once the run reaches MAX_LSU_RUN.
module imem_arb_fair_cnt
    import imem_arb_pkg::*;
#(
    parameter int unsigned MAX_LSU_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch_enable,
    input  logic fetch_gnt,
    input  logic lsu_gnt,
    output logic force_fetch
);

    localparam logic [RUN_CNT_W-1:0] RUN_MAX = RUN_CNT_W'(MAX_LSU_RUN);

    logic [RUN_CNT_W-1:0] run_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (!fetch_enable || fetch_gnt) begin
            run_cnt <= '0;
        end else if (lsu_gnt && (run_cnt != RUN_MAX)) begin
            run_cnt <= run_cnt + RUN_CNT_W'(1);
        end
    end

    assign force_fetch = (run_cnt == RUN_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction RAM between IF fetch and the LSU.
// Optional IMEM_ARB_PERF_EN adds a contention-cycle counter output.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned MAX_LSU_RUN = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    imem_arbiter_if.slave       bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_conflict_cnt_o
`endif
);

    logic      fetch_gnt;
    logic      lsu_gnt;
    logic      force_fetch;
    resp_sel_e resp_q;
    logic [DATA_W-1:0] hold_q;

    // LSU wins contention unless its run has hit the fairness limit.
    assign fetch_gnt = bus.fetch_enable_i & (~bus.lsu_req_i | force_fetch);
    assign lsu_gnt   = bus.lsu_req_i & ~fetch_gnt;

    assign bus.fetch_stall_o = bus.fetch_enable_i & ~fetch_gnt;
    assign bus.lsu_gnt_o     = lsu_gnt;

    imem_arb_fair_cnt #(
        .MAX_LSU_RUN (MAX_LSU_RUN)
    ) u_fair_cnt (
        .clk          (clk_i),
        .rst          (rst_i),
        .fetch_enable (bus.fetch_enable_i),
        .fetch_gnt    (fetch_gnt),
        .lsu_gnt      (lsu_gnt),
        .force_fetch  (force_fetch)
    );

    always_comb begin
        bus.ram_en_o    = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_be_o    = '0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        if (fetch_gnt) begin
            bus.ram_en_o   = 1'b1;
            bus.ram_be_o   = BE_FULL;
            bus.ram_addr_o = bus.fetch_addr_i;
        end else if (lsu_gnt) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = bus.lsu_we_i;
            bus.ram_be_o    = bus.lsu_be_i;
            bus.ram_addr_o  = bus.lsu_addr_i;
            bus.ram_wdata_o = bus.lsu_wdata_i;
        end
    end

    // Tracks who owns the read data returning next cycle; hold_q keeps the
    // last instruction visible while IF is stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_q <= IDLE;
            hold_q <= NOP_INSTR;
        end else begin
            if (resp_q == FETCH_RSP) begin
                hold_q <= bus.ram_rdata_i;
            end
            if (fetch_gnt) begin
                resp_q <= FETCH_RSP;
            end else if (lsu_gnt && !bus.lsu_we_i) begin
                resp_q <= LSU_RSP;
            end else begin
                resp_q <= IDLE;
            end
        end
    end

    assign bus.fetch_rdata_o = (resp_q == FETCH_RSP) ? bus.ram_rdata_i : hold_q;
    assign bus.lsu_rvalid_o  = (resp_q == LSU_RSP);
    assign bus.lsu_rdata_o   = (resp_q == LSU_RSP) ? bus.ram_rdata_i : '0;

`ifdef IMEM_ARB_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_conflict_cnt_o <= '0;
        end else if (bus.fetch_enable_i && bus.lsu_req_i) begin
            perf_conflict_cnt_o <= perf_conflict_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter against a cycle-level reference model.
module tb_imem_arbiter;
    import imem_arb_pkg::*;

    localparam int unsigned MAX_RUN   = 4;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MEM_WORDS = 1024;

    logic clk;
    logic rst;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_cnt;
`endif

    imem_arbiter #(
        .MAX_LSU_RUN (MAX_RUN)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef IMEM_ARB_PERF_EN
        ,
        .perf_conflict_cnt_o (perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 64)  return 32'h0050_0093;
        if (i == 128) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // Environment RAM: synchronous single port, one-cycle read latency
    logic [31:0] ram [MEM_WORDS];
    logic [9:0]  ram_idx;
    assign ram_idx = bus.ram_addr_o[11:2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] <= init_word(i);
            bus.ram_rdata_i <= '0;
        end else if (bus.ram_en_o) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_be_o[b]) ram[ram_idx][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
            end else begin
                bus.ram_rdata_i <= ram[ram_idx];
            end
        end
    end

    // Reference model state
    logic [31:0] m_mem [MEM_WORDS];
    int          m_run;
    logic [31:0] m_fetch_data;
    logic        m_lsu_valid;
    logic [31:0] m_lsu_data;
    int unsigned m_perf;

    int   n_checks;
    int   n_errors;
    logic obs_lsu_gnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(MEM_WORDS); i++) m_mem[i] = init_word(i);
        m_run        = 0;
        m_fetch_data = NOP_INSTR;
        m_lsu_valid  = 1'b0;
        m_lsu_data   = '0;
        m_perf       = 0;
    endtask

    // One clock: drive at negedge, check outputs, advance model on posedge.
    task automatic drive_cycle(input logic fe, input logic [31:0] fa,
                               input logic lr, input logic lw, input logic [3:0] lbe,
                               input logic [31:0] la, input logic [31:0] lwd);
        bit want_f;
        bit want_l;
        int fi;
        int li;
        bus.fetch_enable_i = fe;
        bus.fetch_addr_i   = fa;
        bus.lsu_req_i      = lr;
        bus.lsu_we_i       = lw;
        bus.lsu_be_i       = lbe;
        bus.lsu_addr_i     = la;
        bus.lsu_wdata_i    = lwd;
        #1;
        want_f = fe && (!lr || m_run == int'(MAX_RUN));
        want_l = lr && !want_f;
        fi = int'(fa[11:2]);
        li = int'(la[11:2]);

        check_eq("fetch_stall", 32'(bus.fetch_stall_o), 32'(fe && !want_f));
        check_eq("lsu_gnt",     32'(bus.lsu_gnt_o),     32'(want_l));
        check_eq("ram_en",      32'(bus.ram_en_o),      32'(want_f || want_l));
        check_eq("ram_we",      32'(bus.ram_we_o),      32'(want_l && lw));
        check_eq("ram_be",      32'(bus.ram_be_o),      want_f ? 32'hF : (want_l ? 32'(lbe) : 32'h0));
        check_eq("ram_addr",    bus.ram_addr_o,         want_f ? fa : (want_l ? la : 32'h0));
        check_eq("ram_wdata",   bus.ram_wdata_o,        want_l ? lwd : 32'h0);
        check_eq("fetch_rdata", bus.fetch_rdata_o,      m_fetch_data);
        check_eq("lsu_rvalid",  32'(bus.lsu_rvalid_o),  32'(m_lsu_valid));
        check_eq("lsu_rdata",   bus.lsu_rdata_o,        m_lsu_data);
        obs_lsu_gnt = bus.lsu_gnt_o;

        @(posedge clk);
        if (fe && lr) m_perf++;
        if (want_f) begin
            m_fetch_data = m_mem[fi];
            m_lsu_valid  = 1'b0;
            m_lsu_data   = '0;
        end else if (want_l && !lw) begin
            m_lsu_valid = 1'b1;
            m_lsu_data  = m_mem[li];
        end else begin
            m_lsu_valid = 1'b0;
            m_lsu_data  = '0;
        end
        if (want_l && lw)
            for (int b = 0; b < 4; b++)
                if (lbe[b]) m_mem[li][8*b +: 8] = lwd[8*b +: 8];
        if (!fe || want_f)                        m_run = 0;
        else if (want_l && m_run < int'(MAX_RUN)) m_run++;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    logic [9:0]  pat;
    logic [31:0] exp_word;
    logic        p_req, p_we, r_fe;
    logic [3:0]  p_be;
    logic [31:0] p_addr, p_wdata, r_fa;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.fetch_enable_i = 1'b0;
        bus.fetch_addr_i   = '0;
        bus.lsu_req_i      = 1'b0;
        bus.lsu_we_i       = 1'b0;
        bus.lsu_be_i       = '0;
        bus.lsu_addr_i     = '0;
        bus.lsu_wdata_i    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_fetch_rdata", bus.fetch_rdata_o, 32'h0000_0013);
        check_eq("reset_lsu_rvalid",  32'(bus.lsu_rvalid_o), 32'h0);
        check_eq("reset_lsu_rdata",   bus.lsu_rdata_o, 32'h0);
        rst = 1'b0;

        // Basic fetch, then basic LSU read
        drive_cycle(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_eq("first_fetch", bus.fetch_rdata_o, 32'h0050_0093);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        check_eq("lsu_read", bus.lsu_rdata_o, 32'hDEAD_BEEF);
        check_eq("fetch_hold", bus.fetch_rdata_o, 32'h0050_0093);
        idle_cycle();

        // Continuous contention: LLLLF repeating
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
            pat[9-i] = obs_lsu_gnt;
        end
        check_eq("grant_pattern", 32'(pat), 32'(10'b11110_11110));
        idle_cycle();

        // Partial write then readback
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h300, 32'h1234_5678);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        exp_word = init_word(192);
        exp_word[15:0] = 16'h5678;
        check_eq("write_readback", bus.lsu_rdata_o, exp_word);
        idle_cycle();

        // Reset right after an LSU read grant, with run count non-zero
        drive_cycle(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        drive_cycle(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        rst = 1'b1;
        #1;
        check_eq("midrst_rvalid", 32'(bus.lsu_rvalid_o), 32'h0);
        check_eq("midrst_rdata",  bus.lsu_rdata_o, 32'h0);
        check_eq("midrst_fetch",  bus.fetch_rdata_o, 32'h0000_0013);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
            pat[6-i] = obs_lsu_gnt;
        end
        check_eq("post_rst_pattern", 32'(pat[6:0]), 32'(7'b1111011));
`ifdef IMEM_ARB_PERF_EN
        check_eq("perf_seven", perf_cnt, 32'd7);
`endif

        // Randomized traffic; LSU holds its request until granted
        p_req = 1'b0; p_we = 1'b0; p_be = '0; p_addr = '0; p_wdata = '0;
        for (int n = 0; n < 600; n++) begin
            if (!p_req || obs_lsu_gnt) begin
                p_req   = ($urandom_range(0, 2) != 0);
                p_we    = ($urandom_range(0, 2) == 0);
                p_be    = 4'($urandom_range(1, 15));
                p_addr  = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'b00};
                p_wdata = $urandom;
            end
            r_fe = ($urandom_range(0, 3) != 0);
            r_fa = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'b00};
            drive_cycle(r_fe, r_fa, p_req, p_we, p_be, p_addr, p_wdata);
            if (!p_req) obs_lsu_gnt = 1'b1;
        end
`ifdef IMEM_ARB_PERF_EN
        check_eq("perf_total", perf_cnt, 32'(m_perf));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
